// File: rtl/valve_sequencer_if.sv
// Command/status bundle between the irrigation controller (master) and the valve sequencer (slave).
interface valve_sequencer_if #(
  parameter int FCNT_W = 8
) ();
  logic [1:0]        R1;
  logic [1:0]        R2;
  logic [1:0]        E;
  logic [3:0]        V;
  logic              busy;
  logic              fault;
  logic              active1;
  logic              active2;
  logic [FCNT_W-1:0] fault_cnt;

  modport master (
    output R1, R2, E,
    input  V, busy, fault, active1, active2, fault_cnt
  );

  modport slave (
    input  R1, R2, E,
    output V, busy, fault, active1, active2, fault_cnt
  );
endinterface

// File: rtl/valve_sequencer.sv
// Drives four irrigation valves with staggered opening, minimum on-time and all-close on error.
// state | meaning
// RUN   | valves track {R2,R1}: one open per OPEN_DLY gap, closes honour MIN_ON
// FAULT | all valves closed; leaves once E, R1 and R2 are all zero
module valve_sequencer #(
  parameter int OPEN_DLY = 4,
  parameter int MIN_ON   = 8,
  parameter int FCNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  valve_sequencer_if.slave bus
);
  localparam int ON_W  = $clog2(MIN_ON + 1);
  localparam int GAP_W = $clog2(OPEN_DLY + 1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t            state;
  logic [ON_W-1:0]   on_cnt [4];
  logic [GAP_W-1:0]  gap_cnt;

  logic [3:0]        tgt;
  logic [3:0]        v_n;
  logic [ON_W-1:0]   on_n [4];
  logic [GAP_W-1:0]  gap_n;
  state_t            state_n;
  logic              fault_n;
  logic              busy_n;
  logic [FCNT_W-1:0] fcnt_n;
  logic              opened;

  assign tgt = {bus.R2, bus.R1};

  always_comb begin
    v_n     = bus.V;
    gap_n   = gap_cnt;
    state_n = state;
    fault_n = bus.fault;
    busy_n  = 1'b0;
    fcnt_n  = bus.fault_cnt;
    opened  = 1'b0;
    for (int i = 0; i < 4; i++) on_n[i] = on_cnt[i];

    if (state == RUN && bus.E != 2'b00) begin
      // Error wins over pending opens and the min-on hold.
      v_n     = 4'b0000;
      gap_n   = '0;
      state_n = FAULT;
      fault_n = 1'b1;
      if (bus.fault_cnt != {FCNT_W{1'b1}}) fcnt_n = bus.fault_cnt + 1'b1;
      for (int i = 0; i < 4; i++) on_n[i] = '0;
    end else if (state == RUN) begin
      if (gap_cnt != '0) gap_n = gap_cnt - 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (bus.V[i] && !tgt[i] && on_cnt[i] == ON_W'(MIN_ON)) begin
          v_n[i]  = 1'b0;
          on_n[i] = '0;
        end else if (bus.V[i] && on_cnt[i] != ON_W'(MIN_ON)) begin
          on_n[i] = on_cnt[i] + 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!opened && gap_cnt == '0 && tgt[i] && !bus.V[i]) begin
          v_n[i]  = 1'b1;
          on_n[i] = ON_W'(1);
          gap_n   = GAP_W'(OPEN_DLY - 1);
          opened  = 1'b1;
        end
      end
      busy_n = (v_n != tgt);
    end else begin
      v_n = 4'b0000;
      for (int i = 0; i < 4; i++) on_n[i] = '0;
      if (bus.E == 2'b00 && bus.R1 == 2'b00 && bus.R2 == 2'b00) begin
        state_n = RUN;
        fault_n = 1'b0;
        gap_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      gap_cnt       <= '0;
      for (int i = 0; i < 4; i++) on_cnt[i] <= '0;
      bus.V         <= 4'b0000;
      bus.busy      <= 1'b0;
      bus.fault     <= 1'b0;
      bus.active1   <= 1'b0;
      bus.active2   <= 1'b0;
      bus.fault_cnt <= '0;
    end else begin
      state         <= state_n;
      gap_cnt       <= gap_n;
      for (int i = 0; i < 4; i++) on_cnt[i] <= on_n[i];
      bus.V         <= v_n;
      bus.busy      <= busy_n;
      bus.fault     <= fault_n;
      bus.active1   <= |v_n[1:0];
      bus.active2   <= |v_n[3:2];
      bus.fault_cnt <= fcnt_n;
    end
  end
endmodule

// File: tb/tb_valve_sequencer.sv
// Scenario bench for valve_sequencer: expected status words are queued per edge and popped after it.
module tb_valve_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // {V, busy, fault, active1, active2, fault_cnt}
  logic [15:0] exp_q [$];
  logic [15:0] got;
  logic [15:0] want;

  valve_sequencer_if #(.FCNT_W(8)) bus ();

  valve_sequencer #(.OPEN_DLY(4), .MIN_ON(8), .FCNT_W(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [3:0] v, input logic b, input logic f,
                                     input logic [7:0] fc);
    return {v, b, f, |v[1:0], |v[3:2], fc};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.V, bus.busy, bus.fault, bus.active1, bus.active2, bus.fault_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] e);
    bus.R1 = r1;
    bus.R2 = r2;
    bus.E  = e;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset_hold cyc%0d: got %h want %h", k, got, want);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(mk(4'b0001, 1'b1, 1'b0, 8'd0));
    tick();
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL reset_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_stagger();
    int n;
    apply_reset();
    drive(2'b11, 2'b11, 2'b00);
    for (int k = 1; k <= 14; k++) begin
      n = (k - 1) / 4 + 1;
      if (n > 4) n = 4;
      exp_q.push_back(mk(4'((1 << n) - 1), k < 13, 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL stagger edge%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_min_on();
    apply_reset();
    drive(2'b01, 2'b00, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) drive(2'b00, 2'b00, 2'b00);
      exp_q.push_back(mk({3'b000, k <= 8}, (k >= 3 && k <= 8), 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL min_on edge%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_fault();
    apply_reset();
    drive(2'b11, 2'b11, 2'b00);
    for (int k = 1; k < 20; k++) tick();
    exp_q.push_back(mk(4'b1111, 1'b0, 1'b0, 8'd0));
    tick();
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL fault_pre: got %h want %h", got, want);
    end
    drive(2'b11, 2'b11, 2'b11);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 8'd1));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL fault_entry_hold cyc%0d: got %h want %h", k, got, want);
      end
    end
    drive(2'b01, 2'b11, 2'b00);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 8'd1));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL fault_held_cmd cyc%0d: got %h want %h", k, got, want);
      end
    end
    drive(2'b00, 2'b00, 2'b00);
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 8'd1));
    tick();
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL fault_exit: got %h want %h", got, want);
    end
    drive(2'b01, 2'b00, 2'b00);
    exp_q.push_back(mk(4'b0001, 1'b0, 1'b0, 8'd1));
    tick();
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL fault_reopen: got %h want %h", got, want);
    end
    drive(2'b01, 2'b00, 2'b10);
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 8'd2));
    tick();
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL fault_second: got %h want %h", got, want);
    end
  endtask

  task automatic test_err01();
    apply_reset();
    drive(2'b11, 2'b11, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(k >= 5 ? 4'b0011 : 4'b0001, 1'b1, 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL err01_pre edge%0d: got %h want %h", k, got, want);
      end
    end
    drive(2'b11, 2'b11, 2'b01);
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 8'd1));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL err01 cyc%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(2'b11, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(mk(k == 5 ? 4'b0011 : 4'b0001, k < 5, 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL async_pre edge%0d: got %h want %h", k, got, want);
      end
    end
    #4;
    rst_n = 1'b0;
    exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 8'd0));
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL async_drop: got %h want %h", got, want);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(mk(k >= 5 ? 4'b0011 : 4'b0001, k < 5, 1'b0, 8'd0));
      tick();
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL async_restart edge%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  initial begin
    drive(2'b00, 2'b00, 2'b00);
    test_reset();
    test_stagger();
    test_min_on();
    test_fault();
    test_err01();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/valve_sequencer.md
Name: valve_sequencer

Overview:
- Consumer end of the irrigation controller command interface: takes the per-zone valve commands R1/R2 and error code E and drives the four physical valve outputs.
- Enforces staggered opening to limit pump inrush, a minimum on-time per valve, and immediate all-close on error.
- Reports busy/fault status back to the controller and supervisory logic.

Parameters:
- OPEN_DLY, 4, minimum cycles between two successive valve openings (>=1).
- MIN_ON, 8, minimum cycles a valve stays open once opened (>=1).
- FCNT_W, 8, width of saturating fault-entry counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- R1  in  2  zone-1 valve command; bit0 -> V[0], bit1 -> V[1].
- R2  in  2  zone-2 valve command; bit0 -> V[2], bit1 -> V[3].
- E  in  2  error code from controller; 2'b00 = no error, any other value = error.
- V  out  4  valve drive, 1 = open (registered).
- busy  out  1  V differs from target after the last edge (registered).
- fault  out  1  block is in FAULT state (registered).
- active1  out  1  |V[1:0] (registered).
- active2  out  1  |V[3:2] (registered).
- fault_cnt  out  FCNT_W  number of FAULT entries, saturating (registered).

Behaviour:
- Reset (reset=0, async): V=0, busy=0, fault=0, active1=active2=0, fault_cnt=0, state=RUN, all on_cnt=0, gap_cnt=0.
- Target per cycle: tgt = {R2,R1} when E==00; no target is used when E!=00.
- States: RUN, FAULT. Inputs are sampled at each rising edge, and outputs update at that same edge (1-cycle latency).
- RUN, error: if E!=00 at an edge, then at that edge V=0000, state=FAULT, fault=1, fault_cnt+1 (saturates at all-ones). Error overrides pending opens and the min-on rule.
- RUN, closing: every valve with tgt=0, V=1 and on_cnt==MIN_ON closes at the edge. Multiple valves may close at the same edge.
- RUN, opening: if gap_cnt==0 and any valve has tgt=1 and V=0, the lowest-index such valve opens. Only one valve opens per edge. On opening, gap_cnt<=OPEN_DLY-1 and that valve's on_cnt<=1.
- gap_cnt decrements by 1 per edge while nonzero.
- on_cnt of an open valve increments per edge, saturating at MIN_ON. on_cnt clears when the valve closes.
- Result: an opened valve is high for at least MIN_ON cycles, and openings are spaced at least OPEN_DLY edges apart.
- Closes and an open may occur at the same edge.
- Target changes mid-sequence:
  - A pending open whose tgt drops to 0 is simply not performed.
  - A valve inside its min-on window whose tgt returns to 1 stays open, and its on_cnt keeps counting.
- busy = (V_next != tgt) in RUN; 0 in FAULT.
- active1, active2 are computed from V_next.
- FAULT: V held 0000, fault=1. Exit to RUN at the first edge sampling E==00 and R1==00 and R2==00; fault=0 at that edge. gap_cnt is cleared on exit.
- Remaining in FAULT, including E held at a non-zero value, does not increment fault_cnt again.
- Reset asserted mid-sequence: outputs drop immediately without waiting for a clock. After release, sequencing restarts from V[0] with gap_cnt=0.

Test Plan:
- Reset:
  - Stimulus: reset=0 with R1=11, E=00, clocks running.
  - Required: V=0000, busy=0, fault=0, fault_cnt=0 throughout.
  - Release reset: V=0001 at the first edge.
- Stagger (OPEN_DLY=4):
  - Stimulus: R1=11, R2=11, E=00 applied before edge 1.
  - Required: V=0001@1, 0011@5, 0111@9, 1111@13.
  - busy=1 after edges 1..12, busy=0 after edge 13; active2=1 from edge 9.
- Min-on (MIN_ON=8):
  - Stimulus: R1=01 before edge 1, R1=00 before edge 3.
  - Required: V[0]=1 after edges 1..8, V[0]=0 at edge 9; busy=1 after edges 3..8.
- Fault entry and exit:
  - Stimulus: V=1111 steady; E=11 before edge n.
  - Required at edge n: V=0000, fault=1, fault_cnt=1. Holding E=11 for 5 more edges leaves fault_cnt=1.
  - Then E=00 with R1=01: FAULT is held. Then R1=R2=00: fault=0 at the next edge.
  - A second error later gives fault_cnt=2.
- Non-11 error:
  - Stimulus: E=01 during a stagger sequence.
  - Required: identical to E=11 — V=0000 and fault=1 at the sampling edge; no further opens occur.
- Async reset mid-sequence:
  - Stimulus: V=0011; reset driven low midway between edges.
  - Required: V=0000 before the next edge.
  - After release with R1=11, R2=00: V=0001 at the first edge, 0011 four edges later.
